// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver: active-high glyphs and segment bit positions.
// Bit order is {a,b,c,d,e,f,g,dp} with a in bit 7.
package seg7_scan_driver_pkg;

    localparam int SEG_A_BIT  = 7;
    localparam int SEG_B_BIT  = 6;
    localparam int SEG_C_BIT  = 5;
    localparam int SEG_D_BIT  = 4;
    localparam int SEG_E_BIT  = 3;
    localparam int SEG_F_BIT  = 2;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

    localparam logic [7:0] SEG_0   = 8'hFC;
    localparam logic [7:0] SEG_1   = 8'h60;
    localparam logic [7:0] SEG_2   = 8'hDA;
    localparam logic [7:0] SEG_3   = 8'hF2;
    localparam logic [7:0] SEG_4   = 8'h66;
    localparam logic [7:0] SEG_5   = 8'hB6;
    localparam logic [7:0] SEG_6   = 8'hBE;
    localparam logic [7:0] SEG_7   = 8'hE0;
    localparam logic [7:0] SEG_8   = 8'hFE;
    localparam logic [7:0] SEG_9   = 8'hE6;
    localparam logic [7:0] SEG_A   = 8'hEE;
    localparam logic [7:0] SEG_B   = 8'h3E;
    localparam logic [7:0] SEG_C   = 8'h1A;
    localparam logic [7:0] SEG_D   = 8'h7A;
    localparam logic [7:0] SEG_E   = 8'hDE;
    localparam logic [7:0] SEG_F   = 8'h8E;
    localparam logic [7:0] SEG_OFF = 8'h00;

    // Map an active-high segment pattern onto the pin polarity.
    function automatic logic [7:0] seg_to_pins(input logic [7:0] seg_hi, input logic act_low);
        return act_low ? ~seg_hi : seg_hi;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus-side bundle of the scan driver: display values and load strobe in, status and board pins out.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 8
);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     dp_mask;
    logic [DIGITS-1:0]     blank_mask;
    logic [DIGITS-1:0]     blink_mask;
    logic                  pending;
    logic                  frame_start;
    logic [DIGITS-1:0]     an;
    logic [7:0]            seg;

    modport master (
        output en, load, data, dp_mask, blank_mask, blink_mask,
        input  pending, frame_start, an, seg
    );

    modport slave (
        input  en, load, data, dp_mask, blank_mask, blink_mask,
        output pending, frame_start, an, seg
    );
endinterface

// File: rtl/seg7_scan_driver_decode.sv
// Combinational hex nibble to active-high 7-segment glyph; dp bit is always 0 here.
module hex_seg_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [7:0] o_seg
);

    // Glyph lookup
    always_comb begin
        o_seg = SEG_OFF;
        case (i_nib)
            4'h0:    o_seg = SEG_0;
            4'h1:    o_seg = SEG_1;
            4'h2:    o_seg = SEG_2;
            4'h3:    o_seg = SEG_3;
            4'h4:    o_seg = SEG_4;
            4'h5:    o_seg = SEG_5;
            4'h6:    o_seg = SEG_6;
            4'h7:    o_seg = SEG_7;
            4'h8:    o_seg = SEG_8;
            4'h9:    o_seg = SEG_9;
            4'hA:    o_seg = SEG_A;
            4'hB:    o_seg = SEG_B;
            4'hC:    o_seg = SEG_C;
            4'hD:    o_seg = SEG_D;
            4'hE:    o_seg = SEG_E;
            4'hF:    o_seg = SEG_F;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver. Loads are staged in a pending bank and
// committed to the active bank only at a frame boundary (or at once while scanning is off).
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit AN_ACT_LOW   = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    seg7_scan_driver_if.slave bus
);

    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLK_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [BLK_W-1:0]   BLK_LAST   = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [DIGITS-1:0]  AN_PINS_OFF  = {DIGITS{AN_ACT_LOW}};
    localparam logic [7:0]         SEG_PINS_OFF = {8{SEG_ACT_LOW}};

    logic [PRESC_W-1:0]  r_presc;
    logic [IDX_W-1:0]    r_idx;
    logic [BLK_W-1:0]    r_blk_cnt;
    logic                r_blink_on;
    logic                r_frame_start;
    logic                r_pending;
    logic [4*DIGITS-1:0] r_pnd_data,  r_act_data;
    logic [DIGITS-1:0]   r_pnd_dp,    r_act_dp;
    logic [DIGITS-1:0]   r_pnd_blank, r_act_blank;
    logic [DIGITS-1:0]   r_pnd_blink, r_act_blink;
    logic [DIGITS-1:0]   r_an;
    logic [7:0]          r_seg;

    logic                w_tick;
    logic                w_wrap;
    logic                w_commit;
    logic [DIGITS-1:0]   w_onehot;
    logic [3:0]          w_nib;
    logic                w_dp;
    logic                w_blank;
    logic                w_blink;
    logic [7:0]          w_glyph;
    logic [7:0]          w_seg_hi;

    assign w_tick   = bus.en && (r_presc == PRESC_LAST);
    assign w_wrap   = w_tick && (r_idx == IDX_LAST);
    // With scanning off there are no frame boundaries, so a staged load commits immediately.
    assign w_commit = r_pending && (w_wrap || !bus.en);

    // Prescaler, scan index, frame pulse and blink phase
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_blk_cnt     <= '0;
            r_blink_on    <= 1'b1;
            r_frame_start <= 1'b0;
        end else if (!bus.en) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_blk_cnt     <= '0;
            r_blink_on    <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_presc       <= w_tick ? '0 : r_presc + PRESC_W'(1);
            r_frame_start <= w_wrap;
            if (w_tick) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end
            if (w_wrap) begin
                if (r_blk_cnt == BLK_LAST) begin
                    r_blk_cnt  <= '0;
                    r_blink_on <= ~r_blink_on;
                end else begin
                    r_blk_cnt  <= r_blk_cnt + BLK_W'(1);
                end
            end
        end
    end

    // Pending bank: last load before the boundary wins
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pnd_data  <= '0;
            r_pnd_dp    <= '0;
            r_pnd_blank <= '1;
            r_pnd_blink <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (bus.load) begin
                r_pnd_data  <= bus.data;
                r_pnd_dp    <= bus.dp_mask;
                r_pnd_blank <= bus.blank_mask;
                r_pnd_blink <= bus.blink_mask;
            end
            if (bus.load) begin
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Active bank: takes the pre-edge pending copy, so a same-cycle load waits one more frame
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act_data  <= '0;
            r_act_dp    <= '0;
            r_act_blank <= '1;
            r_act_blink <= '0;
        end else if (w_commit) begin
            r_act_data  <= r_pnd_data;
            r_act_dp    <= r_pnd_dp;
            r_act_blank <= r_pnd_blank;
            r_act_blink <= r_pnd_blink;
        end
    end

    // Select the current digit's attributes and its anode one-hot
    always_comb begin
        w_onehot = '0;
        w_nib    = 4'h0;
        w_dp     = 1'b0;
        w_blank  = 1'b1;
        w_blink  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_onehot[i] = 1'b1;
                w_nib       = r_act_data[4*i +: 4];
                w_dp        = r_act_dp[i];
                w_blank     = r_act_blank[i];
                w_blink     = r_act_blink[i];
            end else begin
                w_onehot[i] = 1'b0;
            end
        end
    end

    hex_seg_decode u_decode (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

    // Apply blanking/blink and the decimal point to the decoded glyph
    always_comb begin
        w_seg_hi = SEG_OFF;
        if (w_blank || (w_blink && !r_blink_on)) begin
            w_seg_hi = SEG_OFF;
        end else begin
            w_seg_hi             = w_glyph;
            w_seg_hi[SEG_DP_BIT] = w_dp;
        end
    end

    // Registered pin drivers, polarity applied last
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_an  <= AN_PINS_OFF;
            r_seg <= SEG_PINS_OFF;
        end else if (!bus.en) begin
            r_an  <= AN_PINS_OFF;
            r_seg <= SEG_PINS_OFF;
        end else begin
            r_an  <= AN_ACT_LOW ? ~w_onehot : w_onehot;
            r_seg <= seg_to_pins(w_seg_hi, SEG_ACT_LOW);
        end
    end

    assign bus.pending     = r_pending;
    assign bus.frame_start = r_frame_start;
    assign bus.an          = r_an;
    assign bus.seg         = r_seg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 4 clk per slot, 2-frame blink, active-low pins).
module tb_seg7_scan_driver;

    localparam int DIGITS = 4;

    typedef struct {
        string       tag;
        logic [11:0] exp;
    } exp_t;

    typedef struct {
        int          at;
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  bl;
        logic [3:0]  bk;
    } ld_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_driver #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2),
        .SEG_ACT_LOW  (1'b1),
        .AN_ACT_LOW   (1'b1)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_miss = 0;
    int          nb = 0;
    logic [7:0]  glyph [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'hDE, 8'h8E};
    ld_t         no_ld = '{-1, 16'h0, 4'h0, 4'h0, 4'h0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] exp_out(input logic [15:0] d, input logic [3:0] dp,
                                            input logic [3:0] bl, input logic [3:0] bk,
                                            input bit ph_on, input int dig);
        logic [7:0] s;
        logic [3:0] nib;
        logic [3:0] sel;
        nib = d[4*dig +: 4];
        if (bl[dig] || (bk[dig] && !ph_on)) s = 8'h00;
        else s = glyph[nib] | {7'b0, dp[dig]};
        sel = 4'b0001 << dig;
        return {~sel, ~s};
    endfunction

    task automatic push_exp(input string tag, input logic [11:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk(e.tag, {20'h0, bus.an, bus.seg}, {20'h0, e.exp});
        end
    endtask

    task automatic drive_ld(input ld_t l);
        bus.load       = 1'b1;
        bus.data       = l.d;
        bus.dp_mask    = l.dp;
        bus.blank_mask = l.bl;
        bus.blink_mask = l.bk;
    endtask

    // One full frame starting at a frame_start sample point; optional loads at slot cycles la.at/lb.at.
    task automatic frame(input string tag, input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] bl, input logic [3:0] bk,
                         input ld_t la, input ld_t lb, input logic pnd_end);
        bit ph_on;
        ph_on = ((nb / 2) % 2) == 0;
        for (int dig = 0; dig < DIGITS; dig++)
            for (int c = 0; c < 4; c++)
                push_exp($sformatf("%s d%0d c%0d", tag, dig, c), exp_out(d, dp, bl, bk, ph_on, dig));
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            pop_chk();
            chk($sformatf("%s frame_start j%0d", tag, j), {31'h0, bus.frame_start}, {31'h0, (j == 16)});
            if ((la.at >= 0 && j == la.at + 1) || (lb.at >= 0 && j == lb.at + 1))
                chk($sformatf("%s pending after load", tag), {31'h0, bus.pending}, 32'd1);
            if (j == 16)
                chk($sformatf("%s pending at boundary", tag), {31'h0, bus.pending}, {31'h0, pnd_end});
            if (j == la.at) drive_ld(la);
            else if (j == lb.at) drive_ld(lb);
            else bus.load = 1'b0;
        end
        bus.load = 1'b0;
        nb++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.en         = 1'b0;
        bus.load       = 1'b0;
        bus.data       = 16'h0;
        bus.dp_mask    = 4'h0;
        bus.blank_mask = 4'h0;
        bus.blink_mask = 4'h0;
        repeat (3) @(negedge clk);
        push_exp("reset pins", 12'hFFF);
        pop_chk();
        chk("reset pending", {31'h0, bus.pending}, 32'd0);
        chk("reset frame_start", {31'h0, bus.frame_start}, 32'd0);

        // Scan from reset: dark frame, then a load mid-frame
        rst_n  = 1'b1;
        bus.en = 1'b1;
        nb     = 0;
        frame("f1 dark", 16'h0000, 4'h0, 4'hF, 4'h0, '{5, 16'h3A7F, 4'b0001, 4'h0, 4'h0}, no_ld, 1'b0);
        frame("f2 3a7f", 16'h3A7F, 4'b0001, 4'h0, 4'h0,
              '{3, 16'h1111, 4'h0, 4'h0, 4'h0}, '{10, 16'h2222, 4'h0, 4'h0, 4'h0}, 1'b0);
        frame("f3 2222", 16'h2222, 4'h0, 4'h0, 4'h0,
              '{4, 16'h9ABC, 4'h0, 4'h0, 4'h0}, '{15, 16'h5678, 4'h0, 4'b0100, 4'b0010}, 1'b1);
        frame("f4 9abc", 16'h9ABC, 4'h0, 4'h0, 4'h0, no_ld, no_ld, 1'b0);
        for (int f = 0; f < 4; f++)
            frame($sformatf("f%0d blink", 5 + f), 16'h5678, 4'h0, 4'b0100, 4'b0010, no_ld, no_ld, 1'b0);

        // Scan enable drops mid-slot; a load while off commits after one clock
        repeat (2) @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        push_exp("en off pins", 12'hFFF);
        pop_chk();
        chk("en off frame_start", {31'h0, bus.frame_start}, 32'd0);
        drive_ld('{0, 16'hBEEF, 4'h0, 4'h0, 4'h0});
        @(negedge clk);
        bus.load = 1'b0;
        chk("en off pending set", {31'h0, bus.pending}, 32'd1);
        push_exp("en off pins 2", 12'hFFF);
        pop_chk();
        @(negedge clk);
        chk("en off commit", {31'h0, bus.pending}, 32'd0);
        bus.en = 1'b1;
        nb     = 0;
        frame("f9 reenable", 16'hBEEF, 4'h0, 4'h0, 4'h0, no_ld, no_ld, 1'b0);

        // Asynchronous reset with a load still pending
        repeat (2) @(negedge clk);
        drive_ld('{0, 16'h4444, 4'h0, 4'h0, 4'h0});
        @(negedge clk);
        bus.load = 1'b0;
        chk("pre-reset pending", {31'h0, bus.pending}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        push_exp("async reset pins", 12'hFFF);
        pop_chk();
        chk("async reset pending", {31'h0, bus.pending}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nb    = 0;
        frame("f10 post-reset", 16'h0000, 4'h0, 4'hF, 4'h0, no_ld, no_ld, 1'b0);
        frame("f11 post-reset", 16'h0000, 4'h0, 4'hF, 4'h0, no_ld, no_ld, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
